// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding, load-use and HI/LO hazard detection
// for the 5-stage pipeline, and a busy tracker for the multi-cycle MULT/DIV unit.
// Optional macro FWD_PERF_CNT_EN adds saturating stall / forward counters
// (perf_stall_cnt, perf_fwd_cnt).
module fwd_hazard_unit #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              uses_rt_id,
    input  logic              mfhilo_id,
    input  logic              muldiv_id,
    input  logic [REG_AW-1:0] rs_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_read_ex,
    input  logic              mult_ex,
    input  logic              div_ex,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              mem_reg_wr,
    input  logic              wb_reg_wr,
    input  logic [DATA_W-1:0] RD1_ex,
    input  logic [DATA_W-1:0] RD2_ex,
    input  logic [DATA_W-1:0] res_mem,
    input  logic [DATA_W-1:0] res_wb,
    output logic [DATA_W-1:0] sourceA_ex,
    output logic [DATA_W-1:0] sourceB_ex,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_ex,
    output logic              hilo_busy,
    output logic              forward_hi_lo,
    output logic              hilo_err
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_fwd_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Counter reload values: the unit stays busy for LAT cycles, counting LAT-1 down to 0.
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              fwd_hilo_q;
    logic              err_q;

    logic [REG_AW-1:0] src_reg [2];
    logic [DATA_W-1:0] rf_val  [2];
    logic [DATA_W-1:0] opnd    [2];
`ifdef FWD_PERF_CNT_EN
    logic [1:0]        fwd_hit;
`endif

    logic              load_use;
    logic              hilo_haz;
    logic              hazard;

    assign src_reg[0] = rs_ex;
    assign src_reg[1] = rt_ex;
    assign rf_val[0]  = RD1_ex;
    assign rf_val[1]  = RD2_ex;

    // Per-operand forwarding mux: the younger MEM result beats WB, r0 is never forwarded.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit;
            logic wb_hit;
            assign mem_hit  = mem_reg_wr && (mem_dst == src_reg[gi]) && (mem_dst != '0);
            assign wb_hit   = wb_reg_wr && (wb_dst == src_reg[gi]) && (wb_dst != '0);
            assign opnd[gi] = mem_hit ? res_mem : (wb_hit ? res_wb : rf_val[gi]);
`ifdef FWD_PERF_CNT_EN
            assign fwd_hit[gi] = mem_hit || wb_hit;
`endif
        end
    endgenerate

    assign sourceA_ex = opnd[0];
    assign sourceB_ex = opnd[1];

    // A load in EX feeding the ID instruction, or any HI/LO access while the unit is busy.
    assign load_use = mem_read_ex && (ex_dst != '0) &&
                      ((ex_dst == rs_id) || (uses_rt_id && (ex_dst == rt_id)));
    assign hilo_haz = (state_q == BUSY) && (mfhilo_id || muldiv_id);
    assign hazard   = load_use || hilo_haz;

    assign stall_if      = hazard;
    assign stall_id      = hazard;
    assign flush_ex      = hazard;
    assign hilo_busy     = (state_q == BUSY);
    assign forward_hi_lo = fwd_hilo_q;
    assign hilo_err      = err_q;

    // MULT/DIV busy tracker; any issue while busy (including the completion edge) is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fwd_hilo_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fwd_hilo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (div_ex) begin
                        state_q <= BUSY;
                        cnt_q   <= DIV_CNT;
                        if (mult_ex) begin
                            err_q <= 1'b1;
                        end
                    end else if (mult_ex) begin
                        state_q <= BUSY;
                        cnt_q   <= MULT_CNT;
                    end
                end
                BUSY: begin
                    if (mult_ex || div_ex) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q    <= IDLE;
                        fwd_hilo_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [32:0] fwd_sum;

    // Saturating event counters: stalled cycles and forwarded operands.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        fwd_sum   = {1'b0, fwd_cnt_q} + 33'(fwd_hit[0]) + 33'(fwd_hit[1]);
        fwd_cnt_d = fwd_sum[32] ? '1 : fwd_sum[31:0];
    end

    // Register the performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage pipeline; successor to the single-cycle EX forwarding mux.
- Selects the EX operands from the register file, the MEM result or the WB result, with correct priority and register-0 suppression.
- Detects load-use hazards and stalls/bubbles the pipeline.
- Tracks the multi-cycle MULT/DIV (HI/LO) unit with a busy state machine, stalls dependent instructions and raises the HI/LO forward strobe on completion.

Parameters:
- DATA_W, 32, datapath width in bits
- REG_AW, 5, register address width
- MULT_LAT, 4, MULT busy cycles (>=2)
- DIV_LAT, 32, DIV busy cycles (>=2)
- CNT_W, 6, latency counter width; must hold max(MULT_LAT,DIV_LAT)-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- rs_id, rt_id  in  REG_AW  ID-stage source registers
- uses_rt_id  in  1  ID instruction reads rt
- mfhilo_id  in  1  ID instruction is MFHI/MFLO
- muldiv_id  in  1  ID instruction is MULT/DIV
- rs_ex, rt_ex  in  REG_AW  EX-stage source registers
- ex_dst  in  REG_AW  EX-stage destination register
- mem_read_ex  in  1  EX instruction is a load
- mult_ex, div_ex  in  1  EX instruction issues MULT / DIV
- mem_dst, wb_dst  in  REG_AW  MEM / WB destination registers
- mem_reg_wr, wb_reg_wr  in  1  MEM / WB write enables
- RD1_ex, RD2_ex  in  DATA_W  register-file operands in EX
- res_mem, res_wb  in  DATA_W  MEM / WB results
- sourceA_ex, sourceB_ex  out  DATA_W  forwarded EX operands
- stall_if, stall_id  out  1  hold PC / IF-ID register
- flush_ex  out  1  insert bubble into ID-EX register
- hilo_busy  out  1  MULT/DIV unit busy
- forward_hi_lo  out  1  one-cycle strobe: HI/LO result valid
- hilo_err  out  1  sticky: overlapping or dual MULT/DIV issue

Behaviour:
- Forwarding (combinational, no latency), per operand:
  - Match MEM: mem_reg_wr & mem_dst==src & mem_dst!=0 -> res_mem.
  - Otherwise match WB: wb_reg_wr & wb_dst==src & wb_dst!=0 -> res_wb.
  - Otherwise RD1_ex / RD2_ex.
  - MEM beats WB. Operand A uses rs_ex, B uses rt_ex; the two are independent, so both may forward in the same cycle.
- Load-use hazard: lu = mem_read_ex & ex_dst!=0 & (ex_dst==rs_id | (uses_rt_id & ex_dst==rt_id)).
- HI/LO hazard: hl = hilo_busy & (mfhilo_id | muldiv_id).
- stall_if = stall_id = flush_ex = lu | hl (combinational). Each stall is held while the condition persists.
- HI/LO FSM, states IDLE and BUSY, with counter cnt[CNT_W]:
  - IDLE, div_ex -> BUSY, cnt=DIV_LAT-1.
  - IDLE, otherwise mult_ex -> BUSY, cnt=MULT_LAT-1.
  - BUSY, cnt!=0 -> cnt decrements.
  - BUSY, cnt==0 -> IDLE; forward_hi_lo registers to 1 for exactly one cycle.
  - hilo_busy = (state==BUSY).
- Timing: an issue seen at edge t gives hilo_busy high for cycles t+1..t+LAT and forward_hi_lo high at t+LAT+1.
- Error cases (state unchanged, hilo_err set, held until reset):
  - mult_ex or div_ex while BUSY: issue ignored.
  - mult_ex & div_ex together in IDLE: DIV accepted.
- Issue at the completion edge (BUSY, cnt==0, mult_ex/div_ex): counts as overlap, issue ignored.
- Reset (any time, including mid-operation): state IDLE, cnt=0, forward_hi_lo=0, hilo_err=0. Combinational outputs follow their inputs with hilo_busy=0.

Optional Feature:
- Macro FWD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_fwd_cnt[31:0].
  - perf_stall_cnt increments on each cycle with stall_id=1.
  - perf_fwd_cnt increments by 0, 1 or 2, the number of operands forwarded (from MEM or WB) that cycle.
  - Both saturate at all-ones and are cleared by rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- rs_ex=3, rt_ex=3, mem_dst=3/mem_reg_wr=1/res_mem=0xAAAA, wb_dst=3/wb_reg_wr=1/res_wb=0x5555 -> sourceA_ex=sourceB_ex=0xAAAA. Drop mem_reg_wr -> both 0x5555.
- mem_dst=0, mem_reg_wr=1, rs_ex=0, RD1_ex=0x1234 -> sourceA_ex=0x1234; no forward of r0.
- mem_read_ex=1, ex_dst=7, rt_id=7, uses_rt_id=1 -> stall_if=stall_id=flush_ex=1 that cycle. Same with uses_rt_id=0 and rs_id!=7 -> all 0.
- mult_ex pulse at edge t, MULT_LAT=4 -> hilo_busy cycles t+1..t+4, forward_hi_lo=1 only at t+5. mfhilo_id held -> stall_id=1 for t+1..t+4, then 0.
- div_ex accepted, then mult_ex at cycle 10 of BUSY -> hilo_err=1, completion still at DIV_LAT. Assert rst at cycle 15 -> hilo_busy=0, hilo_err=0, no forward_hi_lo strobe.
- mult_ex & div_ex together in IDLE, DIV_LAT=32 -> hilo_busy for 32 cycles, hilo_err=1.
